cpu_seg_display: RTL and testbench
==================================

Name: cpu_seg_display

Overview:
- Board-side output stage directly downstream of the cpu top; consumes its cycle_count, display and halt outputs.
- Shows one 32-bit value as 8 hex digits on a time-multiplexed, active-low 7-segment display.
- Latches the cycle count at the first halt.
- Snapshots the shown value once per full scan so digits never tear mid-refresh.

Parameters:
CLK_DIV, 100000, clk cycles each digit stays lit (>=2); sim benches use 4
LZ_BLANK, 1, 1 = blank leading zero digits (digit 0 always shown); 0 = show all 8 digits

Ports:
clk  input  1  system clock, shared with cpu
clr  input  1  synchronous active-high reset
display  input  32  cpu syscall display value
cycle_count  input  32  cpu cycle counter
halt  input  1  cpu halt flag, level
sel  input  1  0 = show display, 1 = show cycle count (frozen value once halted)
an  output  8  digit enables, active low, an[0] = least significant digit
seg  output  7  segments {g,f,e,d,c,b,a}, active low
dp  output  1  decimal point, active low

Behaviour:
- Interface: one clock, clk. Reset clr is synchronous and active-high, sampled only on posedge clk. Everything below is relative to posedge clk.
- Reset (clr=1 at an edge), all registers take these values:
  - div_cnt=0, idx=0, snap=0, halt_seen=0, halt_cycles=0
  - an=8'hFF, seg=7'h7F, dp=1
- clr overrides every other event in the same cycle, including a halt rising edge or a scan wrap.
- Prescaler div_cnt counts 0..CLK_DIV-1 and then wraps to 0. tick=1 when div_cnt==CLK_DIV-1.
- On tick, idx advances 0→1→…→7→0 (3-bit wrap). idx holds when tick=0.
- Halt latch:
  - First edge with halt=1 and halt_seen=0: set halt_seen=1 and halt_cycles=cycle_count as sampled that edge.
  - Later halt activity is ignored. Only clr clears halt_seen and halt_cycles.
- Source mux:
  - src = display when sel=0.
  - src = halt_cycles when sel=1 and halt_seen=1.
  - src = cycle_count otherwise.
- Snapshot: snap<=src on an edge where tick=1 and idx==7, i.e. the same edge idx wraps to 0. snap holds otherwise.
  - snap stays 0 for the first 8*CLK_DIV cycles after reset.
  - Changes to sel or display appear only from the next scan start.
- Digit nibble: nib = snap[4*idx+3 : 4*idx].
- Leading-zero blanking (LZ_BLANK=1): digit k is blank when k>0 and snap[31:4k]==0. A blank digit drives seg=7'h7F with its an still low.
- Registered outputs, one-cycle latency from idx/snap/halt_seen:
  - an <= ~(8'b1 << idx); exactly one bit is low at any time after the first post-reset edge.
  - seg <= hex7(nib), or 7'h7F when blank.
  - dp <= 0 only when idx==7 and halt_seen=1, else 1.
- hex7 encoding, full 16-entry standard hex font, active low:
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
  - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
- Simultaneous scan wrap and halt rise: halt_cycles captures that edge, and snap samples the pre-edge src, since halt_seen is still 0.
- No handshake. Inputs are treated as level signals sampled each edge.

Test Plan:
1. CLK_DIV=4, clr 2 cycles, then release → an=8'hFF and seg=7'h7F during reset. First edge after release: an=8'hFE, seg=7'h40. an steps FE→FD→…→7F at 4-cycle intervals, then back to FE.
2. LZ_BLANK=0, sel=0, display=32'h1234ABCF held for two full scans → second scan: digit0 seg=0E (F), digit1 46 (C), digit2 03 (b), digit3 08 (A), digit4 19 (4), digit5 30 (3), digit6 24 (2), digit7 79 (1).
3. LZ_BLANK=1, display=32'h0000_0050 → second scan: digit0 seg=40, digit1 seg=12, digits 2..7 seg=7F with their an bits still asserted in turn. display=0 → digit0 seg=40, all others 7F.
4. sel=1, cycle_count incrementing, halt pulses high at cycle_count=32'h0000_01F3, then drops, then rises again later → halt_cycles=1F3 and is never overwritten. From the next scan start, digits read 1F3 permanently. dp=0 only while an=8'h7F.
5. display changes from 32'h11111111 to 32'h22222222 mid-scan at idx=3 → digits 4..7 still show 1 for the rest of that scan. All digits show 2 only from the scan after the wrap.
6. halt=1 then clr asserted mid-scan at idx=5 → next edge gives an=FF, seg=7F, dp=1, halt_seen=0. With halt=0 afterwards, sel=1 shows live cycle_count again.

Source files
------------

// File: rtl/cpu_seg_display.sv
// Eight-digit multiplexed hex display for the cpu board: shows the syscall display
// value or the cycle count (frozen at first halt), refreshed one digit per CLK_DIV cycles.
module cpu_seg_display #(
    parameter int CLK_DIV  = 100000,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] display,
    input  logic [31:0] cycle_count,
    input  logic        halt,
    input  logic        sel,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic [2:0]    idx;
    logic [31:0]   snap;
    logic [31:0]   halt_cycles;
    logic          halt_seen;

    logic          tick;
    logic          scan_wrap;
    logic [31:0]   src;
    logic [4:0]    bit_pos;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    glyph;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        s = 7'h7F;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_comb begin
        tick      = (div_cnt == DW'(CLK_DIV - 1));
        scan_wrap = tick && (idx == 3'd7);
        bit_pos   = {idx, 2'b00};
        nib       = snap[bit_pos +: 4];
        glyph     = hex7(nib);
        // Digit 0 is always lit so a zero value still shows a single "0".
        blank     = LZ_BLANK && (idx != 3'd0) && ((snap >> bit_pos) == 32'd0);
        if (!sel)
            src = display;
        else if (halt_seen)
            src = halt_cycles;
        else
            src = cycle_count;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            div_cnt     <= '0;
            idx         <= 3'd0;
            snap        <= 32'd0;
            halt_seen   <= 1'b0;
            halt_cycles <= 32'd0;
            an          <= 8'hFF;
            seg         <= 7'h7F;
            dp          <= 1'b1;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                idx <= idx + 3'd1;
            // Snapshot only at scan wrap so a refresh never mixes two values.
            if (scan_wrap)
                snap <= src;
            if (halt && !halt_seen) begin
                halt_seen   <= 1'b1;
                halt_cycles <= cycle_count;
            end
            an  <= ~(8'b1 << idx);
            seg <= blank ? 7'h7F : glyph;
            dp  <= !((idx == 3'd7) && halt_seen);
        end
    end

endmodule

// File: tb/tb_cpu_seg_display.sv
// Randomized bench for cpu_seg_display: a per-edge reference model derived from the
// edge count since reset checks an/seg/dp of a blanking and a non-blanking instance.
module tb_cpu_seg_display;

    localparam int CLK_DIV = 4;
    localparam int SCAN    = 8 * CLK_DIV;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] display = 32'd0;
    logic [31:0] cycle_count = 32'd0;
    logic        halt = 1'b0;
    logic        sel = 1'b0;
    logic [7:0]  an, an_nz;
    logic [6:0]  seg, seg_nz;
    logic        dp, dp_nz;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state: edges since reset, latched snapshot and halt capture.
    int          m_t = 0;
    logic [31:0] m_snap = 32'd0;
    logic        m_seen = 1'b0;
    logic [31:0] m_hc = 32'd0;

    logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    cpu_seg_display #(.CLK_DIV(CLK_DIV), .LZ_BLANK(1'b1)) dut (
        .clk(clk), .clr(clr), .display(display), .cycle_count(cycle_count),
        .halt(halt), .sel(sel), .an(an), .seg(seg), .dp(dp)
    );

    cpu_seg_display #(.CLK_DIV(CLK_DIV), .LZ_BLANK(1'b0)) dut_nz (
        .clk(clk), .clr(clr), .display(display), .cycle_count(cycle_count),
        .halt(halt), .sel(sel), .an(an_nz), .seg(seg_nz), .dp(dp_nz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic int cur_idx();
        return (m_t / CLK_DIV) % 8;
    endfunction

    // One clock edge: predict outputs from the model, then advance the model.
    task automatic step();
        int          idx;
        int          ndig;
        logic [3:0]  nib;
        logic [6:0]  exp_seg, exp_seg_nz;
        logic [7:0]  exp_an;
        logic        exp_dp;
        logic [31:0] src;
        logic        wrap;
        @(posedge clk);
        if (clr) begin
            exp_an = 8'hFF; exp_seg = 7'h7F; exp_seg_nz = 7'h7F; exp_dp = 1'b1;
            m_t = 0; m_snap = 32'd0; m_seen = 1'b0; m_hc = 32'd0;
        end else begin
            idx  = cur_idx();
            nib  = 4'((m_snap >> (4 * idx)) & 32'hF);
            ndig = 1;
            for (int k = 1; k < 8; k++)
                if ((m_snap >> (4 * k)) != 32'd0) ndig = k + 1;
            exp_an     = ~(8'd1 << idx);
            exp_seg_nz = font[nib];
            exp_seg    = (idx >= ndig) ? 7'h7F : font[nib];
            exp_dp     = !(idx == 7 && m_seen);
            src  = !sel ? display : (m_seen ? m_hc : cycle_count);
            wrap = (m_t % SCAN) == SCAN - 1;
            if (wrap) m_snap = src;
            if (halt && !m_seen) begin
                m_seen = 1'b1;
                m_hc   = cycle_count;
            end
            m_t++;
        end
        #1;
        check("an", 32'(an), 32'(exp_an));
        check("seg", 32'(seg), 32'(exp_seg));
        check("dp", 32'(dp), 32'(exp_dp));
        check("an_nz", 32'(an_nz), 32'(exp_an));
        check("seg_nz", 32'(seg_nz), 32'(exp_seg_nz));
        check("dp_nz", 32'(dp_nz), 32'(exp_dp));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_counting(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            cycle_count = cycle_count + 32'd1;
        end
    endtask

    function automatic logic [31:0] rand_value();
        int          sh;
        logic [31:0] v;
        v  = $urandom;
        sh = $urandom_range(0, 8);
        return (sh == 8) ? 32'd0 : (v >> (4 * sh));
    endfunction

    initial begin
        // Reset held for two edges, then a plain scan of zero.
        clr = 1'b1;
        run(2);
        clr = 1'b0;
        sel = 1'b0;
        display = 32'd0;
        run(2 * SCAN + 8);

        display = 32'h1234ABCF;
        run(2 * SCAN);
        display = 32'h0000_0050;
        run(2 * SCAN);
        display = 32'd0;
        run(2 * SCAN);

        // Mid-scan change at digit 3 must not tear the current scan.
        display = 32'h11111111;
        run(SCAN);
        for (int g = 0; g < SCAN && cur_idx() != 3; g++) step();
        display = 32'h22222222;
        run(2 * SCAN);

        // Halt pulse at 0x1F3, then a second halt later that must be ignored.
        sel = 1'b1;
        cycle_count = 32'h0000_01E0;
        for (int i = 0; i < 6 * SCAN; i++) begin
            halt = (cycle_count == 32'h1F3) ||
                   (cycle_count >= 32'h230 && cycle_count < 32'h238);
            step();
            cycle_count = cycle_count + 32'd1;
        end

        // Clear mid-scan at digit 5 while halt is still high.
        halt = 1'b1;
        for (int g = 0; g < SCAN && cur_idx() != 5; g++) step();
        clr = 1'b1;
        step();
        clr  = 1'b0;
        halt = 1'b0;
        run_counting(3 * SCAN);

        // Random traffic: values with varied leading zeros, sel flips, rare halt/clr.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) display = rand_value();
            if ($urandom_range(0, 49) == 0) sel = ~sel;
            if ($urandom_range(0, 29) == 0)
                cycle_count = rand_value();
            else
                cycle_count = cycle_count + 32'd1;
            halt = ($urandom_range(0, 99) == 0);
            clr  = ($urandom_range(0, 299) == 0);
            step();
        end
        clr = 1'b0;
        halt = 1'b0;
        run(SCAN);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
